// File: rtl/fwd_pkg.sv
// ----------------------------------------------------------------------------
// fwd_pkg
// Shared constants for the ID->EX operand-capture / bypass stage.
//   FWD_SEL_W : width of a per-operand forwarding-source code
//   FWD_RF    : operand taken from the register-file read port
//   FWD_MEM   : operand forwarded from the EX/MEM ALU result
//   FWD_WB    : operand forwarded from the MEM/WB write bus (busW), including
//               operands filled later by snooping writeback after a load
//   REG_ZERO  : architectural zero register number (never forwarded)
// ----------------------------------------------------------------------------
package fwd_pkg;

    localparam int unsigned FWD_SEL_W = 2;

    localparam logic [FWD_SEL_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_WB  = 2'b10;

    localparam logic [31:0] REG_ZERO = '0;

endpackage : fwd_pkg

// File: rtl/fwd_operand_slot.sv
// ----------------------------------------------------------------------------
// fwd_operand_slot
// One source-operand slot of the operand-capture stage. On capture it picks
// the newest producer of the requested register (EX/MEM > MEM/WB > regfile).
// If the newest producer is a load still in EX/MEM, the slot parks with
// pend_q=1 and fills later when the writeback bus carries the tagged register.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   capture                entry is loading a new instruction this edge
//   flush                  drop any pending fill (data/sel kept)
//   src_addr, src_data     requested register and its regfile read value
//   mem_wr_*, mem_is_load  EX/MEM producer
//   wb_wr_*                MEM/WB producer (busW)
//   data_q, sel_q, pend_q  slot state
//   cap_fwd                (FWD_OPERAND_STATS_EN only) capture used a bypass
// ----------------------------------------------------------------------------
module fwd_operand_slot
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 capture,
    input  logic                 flush,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [DATA_W-1:0]    src_data,
    input  logic                 mem_wr_en,
    input  logic [ADDR_W-1:0]    mem_wr_addr,
    input  logic [DATA_W-1:0]    mem_wr_data,
    input  logic                 mem_is_load,
    input  logic                 wb_wr_en,
    input  logic [ADDR_W-1:0]    wb_wr_addr,
    input  logic [DATA_W-1:0]    wb_wr_data,
    output logic [DATA_W-1:0]    data_q,
    output logic [FWD_SEL_W-1:0] sel_q,
    output logic                 pend_q
`ifdef FWD_OPERAND_STATS_EN
    ,
    output logic                 cap_fwd
`endif
);

    logic [ADDR_W-1:0]    tag_q;
    logic [DATA_W-1:0]    data_d;
    logic [ADDR_W-1:0]    tag_d;
    logic [FWD_SEL_W-1:0] sel_d;
    logic                 pend_d;

    logic [DATA_W-1:0]    res_data_s;
    logic [FWD_SEL_W-1:0] res_sel_s;
    logic                 res_pend_s;
    logic                 mem_hit_s;
    logic                 wb_hit_s;
    logic                 fill_hit_s;

    // Newest-wins resolution of the requested register at capture time.
    always_comb begin
        mem_hit_s  = mem_wr_en && (mem_wr_addr == src_addr);
        wb_hit_s   = wb_wr_en && (wb_wr_addr == src_addr);
        res_data_s = src_data;
        res_sel_s  = FWD_RF;
        res_pend_s = 1'b0;
        if (src_addr == REG_ZERO[ADDR_W-1:0]) begin
            // r0 reads as zero no matter what a producer claims to write.
            res_data_s = {DATA_W{1'b0}};
            res_sel_s  = FWD_RF;
        end else if (mem_hit_s && !mem_is_load) begin
            res_data_s = mem_wr_data;
            res_sel_s  = FWD_MEM;
        end else if (mem_hit_s) begin
            // Load result arrives on busW next cycle; keep old data meanwhile.
            res_data_s = data_q;
            res_sel_s  = FWD_WB;
            res_pend_s = 1'b1;
        end else if (wb_hit_s) begin
            res_data_s = wb_wr_data;
            res_sel_s  = FWD_WB;
        end else begin
            res_data_s = src_data;
            res_sel_s  = FWD_RF;
        end
    end

    // Next-state: flush beats capture, capture beats a writeback fill.
    always_comb begin
        fill_hit_s = pend_q && wb_wr_en && (wb_wr_addr == tag_q);
        data_d     = data_q;
        tag_d      = tag_q;
        sel_d      = sel_q;
        pend_d     = pend_q;
        if (flush) begin
            pend_d = 1'b0;
        end else if (capture) begin
            data_d = res_data_s;
            sel_d  = res_sel_s;
            pend_d = res_pend_s;
            tag_d  = res_pend_s ? src_addr : tag_q;
        end else if (fill_hit_s) begin
            data_d = wb_wr_data;
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {DATA_W{1'b0}};
            tag_q  <= {ADDR_W{1'b0}};
            sel_q  <= FWD_RF;
            pend_q <= 1'b0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            sel_q  <= sel_d;
            pend_q <= pend_d;
        end
    end

`ifdef FWD_OPERAND_STATS_EN
    assign cap_fwd = capture && (res_sel_s != FWD_RF);
`endif

endmodule : fwd_operand_slot

// File: rtl/fwd_operand_stage.sv
// ----------------------------------------------------------------------------
// fwd_operand_stage
// Single-entry operand-capture and bypass stage between ID and EX. Holds one
// instruction's NUM_SRC operands; load-dependent operands wait for writeback
// so a load-use hazard shows up as one bubble on ex_valid.
//
// Ports:
//   id_valid/id_ready             ID handshake (id_ready independent of id_valid)
//   id_src_addr/id_src_data       per-operand register number / regfile data
//   mem_wr_*, mem_is_load         EX/MEM producer
//   wb_wr_*                       MEM/WB producer (busW)
//   flush                         discard held instruction
//   ex_valid/ex_ready             EX handshake
//   ex_op_data/ex_fwd_sel         resolved operands and their sources
//   stat_fwd_cnt/stat_bubble_cnt  present only with FWD_OPERAND_STATS_EN
//
// Optional feature macro: FWD_OPERAND_STATS_EN
// ----------------------------------------------------------------------------
module fwd_operand_stage
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_SRC = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid,
    output logic                           id_ready,
    input  logic [NUM_SRC*ADDR_W-1:0]      id_src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]      id_src_data,
    input  logic                           mem_wr_en,
    input  logic [ADDR_W-1:0]              mem_wr_addr,
    input  logic [DATA_W-1:0]              mem_wr_data,
    input  logic                           mem_is_load,
    input  logic                           wb_wr_en,
    input  logic [ADDR_W-1:0]              wb_wr_addr,
    input  logic [DATA_W-1:0]              wb_wr_data,
    input  logic                           flush,
    input  logic                           ex_ready,
    output logic                           ex_valid,
    output logic [NUM_SRC*DATA_W-1:0]      ex_op_data,
    output logic [NUM_SRC*FWD_SEL_W-1:0]   ex_fwd_sel
`ifdef FWD_OPERAND_STATS_EN
    ,
    output logic [31:0]                    stat_fwd_cnt,
    output logic [31:0]                    stat_bubble_cnt
`endif
);

    logic               full_q;
    logic               full_d;
    logic [NUM_SRC-1:0] pend_s;
    logic               capture_s;
    logic               fire_s;

    assign ex_valid  = full_q && !(|pend_s);
    assign fire_s    = ex_valid && ex_ready;
    assign id_ready  = !full_q || fire_s;
    assign capture_s = id_valid && id_ready && !flush;

`ifdef FWD_OPERAND_STATS_EN
    logic [NUM_SRC-1:0] cap_fwd_s;
`endif

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
        fwd_operand_slot #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .capture     (capture_s),
            .flush       (flush),
            .src_addr    (id_src_addr[g*ADDR_W +: ADDR_W]),
            .src_data    (id_src_data[g*DATA_W +: DATA_W]),
            .mem_wr_en   (mem_wr_en),
            .mem_wr_addr (mem_wr_addr),
            .mem_wr_data (mem_wr_data),
            .mem_is_load (mem_is_load),
            .wb_wr_en    (wb_wr_en),
            .wb_wr_addr  (wb_wr_addr),
            .wb_wr_data  (wb_wr_data),
            .data_q      (ex_op_data[g*DATA_W +: DATA_W]),
            .sel_q       (ex_fwd_sel[g*FWD_SEL_W +: FWD_SEL_W]),
            .pend_q      (pend_s[g])
`ifdef FWD_OPERAND_STATS_EN
            ,
            .cap_fwd     (cap_fwd_s[g])
`endif
        );
    end

    // Entry occupancy: a same-cycle capture refills an entry that is firing.
    always_comb begin
        full_d = full_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (capture_s) begin
            full_d = 1'b1;
        end else if (fire_s) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

`ifdef FWD_OPERAND_STATS_EN
    logic [31:0] stat_fwd_cnt_q;
    logic [31:0] stat_fwd_cnt_d;
    logic [31:0] stat_bubble_cnt_q;
    logic [31:0] stat_bubble_cnt_d;
    logic [31:0] fwd_inc_s;

    // Counter next-state: bypassed operands per capture, bubble cycles.
    always_comb begin
        fwd_inc_s = 32'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_inc_s = fwd_inc_s + {31'd0, cap_fwd_s[i]};
        end
        stat_fwd_cnt_d = stat_fwd_cnt_q + fwd_inc_s;
        if (full_q && (|pend_s)) begin
            stat_bubble_cnt_d = stat_bubble_cnt_q + 32'd1;
        end else begin
            stat_bubble_cnt_d = stat_bubble_cnt_q;
        end
    end

    // Statistics registers (wrap modulo 2^32).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd_cnt_q    <= 32'd0;
            stat_bubble_cnt_q <= 32'd0;
        end else begin
            stat_fwd_cnt_q    <= stat_fwd_cnt_d;
            stat_bubble_cnt_q <= stat_bubble_cnt_d;
        end
    end

    assign stat_fwd_cnt    = stat_fwd_cnt_q;
    assign stat_bubble_cnt = stat_bubble_cnt_q;
`endif

endmodule : fwd_operand_stage

// File: tb/tb_fwd_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_fwd_operand_stage
// Directed-vector bench for fwd_operand_stage with DATA_W=32, ADDR_W=5,
// NUM_SRC=2. Inputs change 1 time unit after the rising edge; outputs are
// examined before the next rising edge.
// ----------------------------------------------------------------------------
module tb_fwd_operand_stage;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 2;

    logic                         clk;
    logic                         rst_n;
    logic                         id_valid;
    logic                         id_ready;
    logic [NUM_SRC*ADDR_W-1:0]    id_src_addr;
    logic [NUM_SRC*DATA_W-1:0]    id_src_data;
    logic                         mem_wr_en;
    logic [ADDR_W-1:0]            mem_wr_addr;
    logic [DATA_W-1:0]            mem_wr_data;
    logic                         mem_is_load;
    logic                         wb_wr_en;
    logic [ADDR_W-1:0]            wb_wr_addr;
    logic [DATA_W-1:0]            wb_wr_data;
    logic                         flush;
    logic                         ex_ready;
    logic                         ex_valid;
    logic [NUM_SRC*DATA_W-1:0]    ex_op_data;
    logic [NUM_SRC*2-1:0]         ex_fwd_sel;

    int checks   = 0;
    int failures = 0;

    fwd_operand_stage #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_src_addr (id_src_addr),
        .id_src_data (id_src_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_is_load (mem_is_load),
        .wb_wr_en    (wb_wr_en),
        .wb_wr_addr  (wb_wr_addr),
        .wb_wr_data  (wb_wr_data),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_op_data  (ex_op_data),
        .ex_fwd_sel  (ex_fwd_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        id_valid    = 1'b0;
        id_src_addr = '0;
        id_src_data = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = 5'd0;
        mem_wr_data = 32'd0;
        mem_is_load = 1'b0;
        wb_wr_en    = 1'b0;
        wb_wr_addr  = 5'd0;
        wb_wr_data  = 32'd0;
        flush       = 1'b0;
        ex_ready    = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        checks++;
        if (ex_valid !== 1'b0) begin
            $display("FAIL reset_ex_valid got=%b exp=0", ex_valid);
            failures++;
        end
        checks++;
        if (ex_op_data !== 64'd0) begin
            $display("FAIL reset_op_data got=%h exp=0", ex_op_data);
            failures++;
        end
        checks++;
        if (ex_fwd_sel !== 4'b0000) begin
            $display("FAIL reset_fwd_sel got=%b exp=0000", ex_fwd_sel);
            failures++;
        end
        checks++;
        if (id_ready !== 1'b1) begin
            $display("FAIL reset_id_ready got=%b exp=1", id_ready);
            failures++;
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_no_hazard();
        idle();
        id_valid    = 1'b1;
        id_src_addr = {5'd4, 5'd3};
        id_src_data = {32'h22, 32'h11};
        step();
        idle();
        checks++;
        if (ex_valid !== 1'b1) begin
            $display("FAIL nohaz_valid got=%b exp=1", ex_valid);
            failures++;
        end
        checks++;
        if (ex_op_data !== {32'h22, 32'h11}) begin
            $display("FAIL nohaz_data got=%h exp=%h", ex_op_data, {32'h22, 32'h11});
            failures++;
        end
        checks++;
        if (ex_fwd_sel !== 4'b0000) begin
            $display("FAIL nohaz_sel got=%b exp=0000", ex_fwd_sel);
            failures++;
        end
        step();
        checks++;
        if (ex_valid !== 1'b0) begin
            $display("FAIL nohaz_drain got=%b exp=0", ex_valid);
            failures++;
        end
    endtask

    task automatic test_priority();
        idle();
        id_valid    = 1'b1;
        id_src_addr = {5'd0, 5'd5};
        id_src_data = {32'h77, 32'h1234};
        mem_wr_en   = 1'b1;
        mem_wr_addr = 5'd5;
        mem_wr_data = 32'hAAAA;
        wb_wr_en    = 1'b1;
        wb_wr_addr  = 5'd5;
        wb_wr_data  = 32'hBBBB;
        step();
        checks++;
        if (ex_op_data[31:0] !== 32'hAAAA || ex_fwd_sel[1:0] !== 2'b01) begin
            $display("FAIL prio_mem got=%h/%b exp=0000aaaa/01", ex_op_data[31:0], ex_fwd_sel[1:0]);
            failures++;
        end
        // Back-to-back capture with only the WB writer active.
        mem_wr_en = 1'b0;
        step();
        idle();
        checks++;
        if (ex_op_data !== {32'h0, 32'hBBBB} || ex_fwd_sel !== 4'b0010) begin
            $display("FAIL prio_wb got=%h/%b exp=%h/0010", ex_op_data, ex_fwd_sel, {32'h0, 32'hBBBB});
            failures++;
        end
        step();
    endtask

    task automatic test_load_use();
        idle();
        id_valid    = 1'b1;
        id_src_addr = {5'd7, 5'd3};
        id_src_data = {32'h9999, 32'h33};
        mem_wr_en   = 1'b1;
        mem_wr_addr = 5'd7;
        mem_wr_data = 32'hDEAD;
        mem_is_load = 1'b1;
        step();
        idle();
        checks++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin
            $display("FAIL lu_bubble got=%b%b exp=00", ex_valid, id_ready);
            failures++;
        end
        wb_wr_en   = 1'b1;
        wb_wr_addr = 5'd7;
        wb_wr_data = 32'hC0DE;
        step();
        idle();
        checks++;
        if (ex_valid !== 1'b1) begin
            $display("FAIL lu_valid got=%b exp=1", ex_valid);
            failures++;
        end
        checks++;
        if (ex_op_data !== {32'hC0DE, 32'h33} || ex_fwd_sel !== 4'b1000) begin
            $display("FAIL lu_data got=%h/%b exp=%h/1000", ex_op_data, ex_fwd_sel, {32'hC0DE, 32'h33});
            failures++;
        end
        step();
    endtask

    task automatic test_r0_guard();
        idle();
        id_valid    = 1'b1;
        id_src_addr = {5'd0, 5'd0};
        id_src_data = {32'h5555, 32'h1234};
        mem_wr_en   = 1'b1;
        mem_wr_addr = 5'd0;
        mem_wr_data = 32'hFFFF;
        wb_wr_en    = 1'b1;
        wb_wr_addr  = 5'd0;
        wb_wr_data  = 32'hEEEE;
        step();
        idle();
        checks++;
        if (ex_op_data !== 64'd0 || ex_fwd_sel !== 4'b0000 || ex_valid !== 1'b1) begin
            $display("FAIL r0_guard got=%h/%b/%b exp=0/0000/1", ex_op_data, ex_fwd_sel, ex_valid);
            failures++;
        end
        step();
    endtask

    task automatic test_backpressure_flush();
        idle();
        ex_ready    = 1'b0;
        id_valid    = 1'b1;
        id_src_addr = {5'd9, 5'd8};
        id_src_data = {32'h99, 32'h88};
        step();
        for (int i = 0; i < 3; i++) begin
            id_src_addr = {5'd2, 5'd1};
            id_src_data = {32'h1000 + i, 32'h2000 + i};
            checks++;
            if (ex_op_data !== {32'h99, 32'h88} || id_ready !== 1'b0 || ex_valid !== 1'b1) begin
                $display("FAIL bp_hold%0d got=%h rdy=%b v=%b exp=%h rdy=0 v=1",
                         i, ex_op_data, id_ready, ex_valid, {32'h99, 32'h88});
                failures++;
            end
            step();
        end
        // Flush while a capture and a fire would otherwise happen.
        ex_ready    = 1'b1;
        flush       = 1'b1;
        id_src_data = {32'h66, 32'h55};
        step();
        idle();
        checks++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
            $display("FAIL flush_empty got=v%b rdy%b exp=v0 rdy1", ex_valid, id_ready);
            failures++;
        end
        checks++;
        if (ex_op_data !== {32'h99, 32'h88}) begin
            $display("FAIL flush_nocap got=%h exp=%h", ex_op_data, {32'h99, 32'h88});
            failures++;
        end
        // Reset while an operand is waiting on a load.
        id_valid    = 1'b1;
        id_src_addr = {5'd0, 5'd6};
        id_src_data = {32'h0, 32'h6};
        mem_wr_en   = 1'b1;
        mem_wr_addr = 5'd6;
        mem_is_load = 1'b1;
        step();
        idle();
        wb_wr_en   = 1'b1;
        wb_wr_addr = 5'd6;
        wb_wr_data = 32'h6666;
        rst_n      = 1'b0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_op_data !== 64'd0) begin
            $display("FAIL rst_pend got=v%b rdy%b d=%h exp=v0 rdy1 d=0", ex_valid, id_ready, ex_op_data);
            failures++;
        end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_op_data !== 64'd0) begin
            $display("FAIL rst_hold got=v%b d=%h exp=v0 d=0", ex_valid, ex_op_data);
            failures++;
        end
        rst_n = 1'b1;
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        int fires;
        fires = 0;
        idle();
        for (int i = 0; i < 8; i++) begin
            id_valid    = 1'b1;
            id_src_addr = {5'(i + 10), 5'(i + 1)};
            id_src_data = {32'h100 + 32'(i), 32'h200 + 32'(i)};
            step();
            if (ex_valid === 1'b1 && ex_ready === 1'b1) fires++;
            checks++;
            if (ex_valid !== 1'b1 || id_ready !== 1'b1 ||
                ex_op_data !== {32'h100 + 32'(i), 32'h200 + 32'(i)}) begin
                $display("FAIL b2b%0d got=v%b rdy%b d=%h exp=v1 rdy1 d=%h", i, ex_valid, id_ready,
                         ex_op_data, {32'h100 + 32'(i), 32'h200 + 32'(i)});
                failures++;
            end
        end
        idle();
        step();
        checks++;
        if (fires !== 8 || ex_valid !== 1'b0) begin
            $display("FAIL b2b_fires got=%0d v=%b exp=8 v=0", fires, ex_valid);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_priority();
        test_load_use();
        test_r0_guard();
        test_backpressure_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fwd_operand_stage

// File: doc/fwd_operand_stage.md
Name: fwd_operand_stage

Overview:
- Parametrised operand-capture and bypass stage at the ID→EX boundary of the 5-stage pipeline.
- Holds one instruction's NUM_SRC source operands.
- On capture, resolves each operand from the regfile read value, EX/MEM result or MEM/WB busW with newest-wins priority.
- Operands that depend on an in-flight load are parked and filled by snooping the writeback bus, so load-use hazards appear as bubbles, not wrong data.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width
- NUM_SRC, 2, source operands per instruction

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID offers an instruction
- id_ready  out  1  stage can accept
- id_src_addr  in  NUM_SRC*ADDR_W  source register numbers; operand i at bits [i*ADDR_W +: ADDR_W]
- id_src_data  in  NUM_SRC*DATA_W  regfile read data
- mem_wr_en  in  1  EX/MEM instruction writes a register
- mem_wr_addr  in  ADDR_W  its destination
- mem_wr_data  in  DATA_W  its ALU result
- mem_is_load  in  1  EX/MEM instruction is a load; data not yet available
- wb_wr_en  in  1  MEM/WB writes the regfile
- wb_wr_addr  in  ADDR_W  writeback destination
- wb_wr_data  in  DATA_W  writeback data (busW)
- flush  in  1  discard held instruction
- ex_ready  in  1  EX accepts
- ex_valid  out  1  operands complete and presented
- ex_op_data  out  NUM_SRC*DATA_W  resolved operands
- ex_fwd_sel  out  NUM_SRC*2  source used per operand: 00 regfile, 01 EX/MEM, 10 MEM/WB

Behaviour:
- State is one entry: full, and per operand data[DATA_W], tag[ADDR_W], pend, sel[2].
- Reset (rst_n=0, asynchronous): full=0, all pend=0, data=0, sel=00. Outputs ex_valid=0, ex_op_data=0, ex_fwd_sel=0, id_ready=1.
- id_ready = !full || (ex_valid && ex_ready). It is combinational, with no dependence on id_valid.
- Capture occurs on the rising edge when id_valid && id_ready && !flush. For each operand i with address a:
  - a==0: data=0, sel=00, pend=0. Forwarding is never applied to r0.
  - else mem_wr_en && mem_wr_addr==a && !mem_is_load: data=mem_wr_data, sel=01.
  - else mem_wr_en && mem_wr_addr==a && mem_is_load: pend=1, tag=a, sel=10, data unchanged.
  - else wb_wr_en && wb_wr_addr==a: data=wb_wr_data, sel=10.
  - else: data=id_src_data slice, sel=00.
  - EX/MEM outranks MEM/WB when both match.
- Fill: each cycle an operand with pend=1 and no flush checks wb_wr_en && wb_wr_addr==tag. On a match it sets data=wb_wr_data and pend=0 at that edge.
- ex_valid = full && no pend bits set. It is combinational from registers.
- Fire: ex_valid && ex_ready. The entry empties (full=0) unless a capture occurs in the same cycle, in which case the new instruction overwrites the entry with full=1. Back-to-back throughput is one instruction per cycle.
- Load-use latency: a dependent operand fills one cycle after capture, so ex_valid rises one cycle late. This is exactly one bubble.
- Flush takes priority over capture, fill and fire. The next edge gives full=0 and all pend=0; data and sel are left unchanged.
- While full with ex_ready=0, the entry holds data and sel stable. Pending fills still complete.
- ex_op_data and ex_fwd_sel are driven directly from the entry registers, independent of full.

Optional Feature:
- Macro: FWD_OPERAND_STATS_EN.
- When defined, the block adds two 32-bit outputs:
  - stat_fwd_cnt: increments by the number of operands captured with sel≠00 per capture.
  - stat_bubble_cnt: increments each cycle with full && any pend.
  - Both clear on reset and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - FWD_SEL_W=2
  - constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - REG_ZERO='0
- Sub-module fwd_operand_slot holds per-operand priority resolve, pend/tag/data registers and the fill snoop. It is instantiated NUM_SRC times by generate.
- The top level owns full, the handshake, flush and the stats.

Test Plan:
- No hazard: capture addrs {3,4}, regfile {0x11,0x22}, no writers, ex_ready=1 → next cycle ex_valid=1, ex_op_data={0x11,0x22}, sel={00,00}.
- Priority: both stages write r5 (MEM 0xAAAA, WB 0xBBBB), operand0=r5 → 0xAAAA, sel 01. With mem_wr_en=0 → 0xBBBB, sel 10.
- Load-use: mem_is_load=1 to r7, operand1=r7. Cycle+1: ex_valid=0. WB writes r7=0xC0DE. Cycle+2: ex_valid=1, op1=0xC0DE, sel 10.
- r0 guard: operand0=r0, mem_wr_en to r0 with 0xFFFF → op0=0, sel 00.
- Backpressure/flush: hold ex_ready=0 for 3 cycles → data stable and id_ready=0. Assert flush with id_valid=1 → next cycle ex_valid=0 and nothing captured. Deassert rst_n mid-pending → immediately ex_valid=0.
- Throughput: 8 consecutive id_valid with ex_ready=1 → 8 fires on 8 consecutive cycles.
